rr_mux_stage: RTL and testbench
===============================

Name: rr_mux_stage

Overview:
- Parametrised N-channel successor to the combinational 4:1 datapath mux.
- Each cycle it selects one of NUM_CHANNELS valid/ready source channels, using round-robin or fixed priority.
- The winner's data is captured into a single output register stage, so downstream sees registered data together with the index of the channel it came from.
- It sits between multiple datapath producers (e.g. writeback sources) and a single consumer that may stall.

Parameters:
- DATA_BIT_WIDTH, 32, width of each channel's data word.
- NUM_CHANNELS, 4, number of source channels; legal range 2..16.
- SEL_BIT_WIDTH, $clog2(NUM_CHANNELS), width of the channel index (derived; do not override).
- ROUND_ROBIN, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  NUM_CHANNELS  per-channel request; bit i belongs to channel i.
- in_data  input  NUM_CHANNELS*DATA_BIT_WIDTH  flattened channel data; channel i occupies [i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH].
- in_ready  output  NUM_CHANNELS  per-channel accept, one-hot or zero.
- out_valid  output  1  output register holds a word.
- out_data  output  DATA_BIT_WIDTH  registered selected data.
- out_sel  output  SEL_BIT_WIDTH  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last_grant=NUM_CHANNELS-1, so channel 0 has highest priority after reset.
- Transfer rules:
  - Channel i transfers when in_valid[i] & in_ready[i].
  - Output transfers when out_valid & out_ready.
- can_load = !out_valid | out_ready. This allows a full-throughput refill in the same cycle the output drains.
- Grant (combinational):
  - When can_load=0: in_ready=0.
  - When can_load=1 and ROUND_ROBIN=1: grant the first i with in_valid[i]=1, searching last_grant+1, last_grant+2, ..., wrapping modulo NUM_CHANNELS.
  - When can_load=1 and ROUND_ROBIN=0: grant the lowest i with in_valid[i]=1.
  - in_ready is one-hot on the granted channel, or all zero if no request.
- in_ready[i] may depend combinationally on in_valid and out_ready. Sources must not make in_valid depend on in_ready.
- On a clock edge with a grant to channel g: out_data<=channel g data, out_sel<=g, out_valid<=1. If ROUND_ROBIN=1, last_grant<=g.
- On a clock edge with an output transfer and no grant: out_valid<=0. out_data and out_sel hold their previous values.
- With no transfer either way, all registers hold. Data is stable while out_valid=1 and out_ready=0.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Fairness (ROUND_ROBIN=1): with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0. No channel waits more than NUM_CHANNELS-1 grants.
- last_grant is unchanged when there is no grant. Wrap: after granting N-1, the search starts at 0.
- Simultaneous drain and load in one cycle: the new word replaces the old; out_valid stays 1; no bubble.
- A reset asserted mid-operation discards the held word immediately (out_valid=0) and reloads last_grant. In-flight input handshakes are not completed.
- No combinational path from in_data to out_data.

Decomposition:
- Shared package mux_pkg: the function for the channel-index width, and constants ARB_RR=1 / ARB_FIXED=0.
- One natural sub-module: rr_arbiter (NUM_CHANNELS, ROUND_ROBIN).
  - Ports: clk, reset_n, req, enable, grant_onehot, grant_idx, grant_valid.
  - It owns last_grant.
- Top level contains the data select and the output register.

Test Plan:
1. Reset with in_valid=4'b1111 held: out_valid=0, out_data=0, in_ready=0 while reset_n=0. After release with out_ready=1, out_sel sequence is 0,1,2,3,0 on consecutive cycles, and out_data matches each channel's data.
2. Backpressure: load channel 2 data 32'hDEADBEEF, then hold out_ready=0 for 5 cycles while in_valid=4'b0011. Required: out_data stays DEADBEEF, out_sel stays 2, in_ready=0. On out_ready=1, channel 0 is granted (wrap after 2 → search 3,0).
3. Same-cycle drain and load: out_valid=1, out_ready=1, in_valid=4'b1000 with data 32'h12345678. Next cycle: out_valid=1, out_data=12345678, out_sel=3, with no bubble cycle.
4. Fixed priority (ROUND_ROBIN=0): in_valid=4'b1110 held with out_ready=1. Required: out_sel=1 every cycle, and channels 2 and 3 never see in_ready=1.
5. Reset mid-operation: out_valid=1 holding channel 1 data; assert reset_n=0 asynchronously. Required: out_valid=0 before the next edge. After release, priority restarts at channel 0.
6. Idle drain: out_valid=1, out_ready=1, in_valid=0. Next cycle: out_valid=0, in_ready=0, and last_grant unchanged, checked by the next grant order.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg: shared arbitration constants and channel-index width helper
package mux_pkg;
  localparam bit ARB_RR = 1'b1;
  localparam bit ARB_FIXED = 1'b0;
  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin/fixed-priority arbiter owning last_grant (clk, reset_n, req, enable -> grant_onehot, grant_idx, grant_valid)
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter bit ROUND_ROBIN = ARB_RR,
  parameter int SEL_BIT_WIDTH = sel_width(NUM_CHANNELS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CHANNELS-1:0]  req,
  input  logic                     enable,
  output logic [NUM_CHANNELS-1:0]  grant_onehot,
  output logic [SEL_BIT_WIDTH-1:0] grant_idx,
  output logic                     grant_valid
);
  logic [SEL_BIT_WIDTH-1:0] last_grant;
  logic found;
  always_comb begin
    found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      int idx;
      idx = ROUND_ROBIN ? (int'(last_grant) + 1 + k) % NUM_CHANNELS : k;
      if (!found && req[idx]) begin
        found = 1'b1;
        grant_idx = SEL_BIT_WIDTH'(idx);
      end
    end
    grant_valid = enable & found;
    grant_onehot = '0;
    grant_onehot[grant_idx] = grant_valid;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= SEL_BIT_WIDTH'(NUM_CHANNELS - 1);
    else if (ROUND_ROBIN && grant_valid) last_grant <= grant_idx;
endmodule

// File: rtl/rr_mux_stage.sv
// rr_mux_stage: N-channel valid/ready arbitrated mux into one output register (in_valid/in_data/in_ready -> out_valid/out_data/out_sel/out_ready)
module rr_mux_stage
  import mux_pkg::*;
#(
  parameter int DATA_BIT_WIDTH = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int SEL_BIT_WIDTH = sel_width(NUM_CHANNELS),
  parameter bit ROUND_ROBIN = ARB_RR
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [NUM_CHANNELS-1:0]                in_valid,
  input  logic [NUM_CHANNELS*DATA_BIT_WIDTH-1:0] in_data,
  output logic [NUM_CHANNELS-1:0]                in_ready,
  output logic                                   out_valid,
  output logic [DATA_BIT_WIDTH-1:0]              out_data,
  output logic [SEL_BIT_WIDTH-1:0]               out_sel,
  input  logic                                   out_ready
);
  logic [SEL_BIT_WIDTH-1:0] grant_idx;
  logic grant_valid;
  logic can_load;
  assign can_load = reset_n & (!out_valid | out_ready);
  rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .ROUND_ROBIN  (ROUND_ROBIN),
    .SEL_BIT_WIDTH(SEL_BIT_WIDTH)
  ) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (in_valid),
    .enable      (can_load),
    .grant_onehot(in_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
    end else if (grant_valid) begin
      out_valid <= 1'b1;
      out_data <= in_data[int'(grant_idx)*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
      out_sel <= grant_idx;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_rr_mux_stage.sv
// tb_rr_mux_stage: directed self-checking bench for round-robin and fixed-priority rr_mux_stage
module tb_rr_mux_stage;
  logic clk = 1'b0;
  logic reset_n;
  logic [3:0] in_valid, in_ready, f_in_valid, f_in_ready;
  logic [31:0] d [4];
  logic [127:0] in_data;
  logic out_valid, out_ready, f_out_valid, f_out_ready;
  logic [31:0] out_data, f_out_data;
  logic [1:0] out_sel, f_out_sel;
  int checks = 0;
  int passes = 0;
  assign in_data = {d[3], d[2], d[1], d[0]};
  always #5 clk = ~clk;
  rr_mux_stage #(.DATA_BIT_WIDTH(32), .NUM_CHANNELS(4), .ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready)
  );
  rr_mux_stage #(.DATA_BIT_WIDTH(32), .NUM_CHANNELS(4), .ROUND_ROBIN(1'b0)) dut_fixed (
    .clk(clk), .reset_n(reset_n), .in_valid(f_in_valid), .in_data(in_data), .in_ready(f_in_ready),
    .out_valid(f_out_valid), .out_data(f_out_data), .out_sel(f_out_sel), .out_ready(f_out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  initial begin
    reset_n = 1'b0;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    f_in_valid = 4'b0000;
    f_out_ready = 1'b1;
    d[0] = 32'hA0A0_0000;
    d[1] = 32'hB1B1_1111;
    d[2] = 32'hC2C2_2222;
    d[3] = 32'hD3D3_3333;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    #1 chk("first_in_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_sel", 32'(out_sel), 32'(i % 4));
      chk("rr_data", out_data, d[i % 4]);
      chk("rr_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 4'b0100;
    d[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("bp_load_sel", 32'(out_sel), 32'd2);
    out_ready = 1'b0;
    in_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_data", out_data, 32'hDEAD_BEEF);
      chk("bp_sel", 32'(out_sel), 32'd2);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("bp_wrap_ready", 32'(in_ready), 32'b0001);
    @(negedge clk);
    chk("bp_wrap_sel", 32'(out_sel), 32'd0);
    chk("bp_wrap_data", out_data, d[0]);
    in_valid = 4'b1000;
    d[3] = 32'h1234_5678;
    #1 chk("dl_in_ready", 32'(in_ready), 32'b1000);
    @(negedge clk);
    chk("dl_valid", 32'(out_valid), 32'd1);
    chk("dl_data", out_data, 32'h1234_5678);
    chk("dl_sel", 32'(out_sel), 32'd3);
    in_valid = 4'b0000;
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_hold_sel", 32'(out_sel), 32'd3);
    in_valid = 4'b1111;
    @(negedge clk);
    chk("idle_next_sel", 32'(out_sel), 32'd0);
    @(negedge clk);
    chk("idle_next2_sel", 32'(out_sel), 32'd1);
    chk("idle_next2_data", out_data, d[1]);
    in_valid = 4'b0000;
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_restart_sel", 32'(out_sel), 32'd0);
    chk("mid_rst_restart_data", out_data, d[0]);
    f_in_valid = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fp_in_ready", 32'(f_in_ready), 32'b0010);
      @(negedge clk);
      chk("fp_sel", 32'(f_out_sel), 32'd1);
      chk("fp_data", f_out_data, d[1]);
      chk("fp_valid", 32'(f_out_valid), 32'd1);
    end
    f_in_valid = 4'b1100;
    #1 chk("fp_low_ready", 32'(f_in_ready), 32'b0100);
    @(negedge clk);
    chk("fp_low_sel", 32'(f_out_sel), 32'd2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
